// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over GATE_MS ce1ms ticks
// and publishes the count with a one-cycle valid strobe; windows run back-to-back.
module freq_meter #(
  parameter int unsigned GATE_MS = 1000,
  parameter int unsigned CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce1ms,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned    MS_W    = (GATE_MS > 1) ? $clog2(GATE_MS) : 1;
  localparam logic [MS_W-1:0] MS_LOAD = MS_W'(GATE_MS - 1);

  typedef enum logic {StAlign, StGate} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              rise;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  edge_inc;
  logic              win_ovf_q, win_ovf_d;
  logic              at_max, ovf_inc;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  assign rise     = s2_q & ~s3_q;
  assign at_max   = &edge_cnt_q;
  // Saturating increment: the counter holds at all-ones and flags the window instead.
  assign edge_inc = at_max ? edge_cnt_q : edge_cnt_q + 1'b1;
  assign ovf_inc  = win_ovf_q | at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= StAlign;
      ms_cnt_q   <= '0;
      edge_cnt_q <= '0;
      win_ovf_q  <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      win_ovf_q  <= win_ovf_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ms_cnt_d   = ms_cnt_q;
    edge_cnt_d = edge_cnt_q;
    win_ovf_d  = win_ovf_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    unique case (state_q)
      StAlign: begin
        // Edges are ignored until the first tick so every window spans whole ms periods.
        if (ce1ms) begin
          state_d    = StGate;
          ms_cnt_d   = MS_LOAD;
          edge_cnt_d = '0;
          win_ovf_d  = 1'b0;
        end
      end
      StGate: begin
        if (ce1ms && (ms_cnt_q == '0)) begin
          // A rise on the closing cycle belongs to the window being closed.
          freq_d     = rise ? edge_inc : edge_cnt_q;
          ovf_d      = rise ? ovf_inc : win_ovf_q;
          valid_d    = 1'b1;
          ms_cnt_d   = MS_LOAD;
          edge_cnt_d = '0;
          win_ovf_d  = 1'b0;
        end else begin
          if (rise) begin
            edge_cnt_d = edge_inc;
            win_ovf_d  = ovf_inc;
          end
          if (ce1ms) begin
            ms_cnt_d = ms_cnt_q - 1'b1;
          end
        end
      end
    endcase
  end

  assign freq  = freq_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule
